move_ctrl: RTL and testbench
============================

// Module: move_ctrl
// PURPOSE
//  Player-input front end for the tic-tac-toe board block. Debounces six push-buttons and keeps a
//  cursor. Turns a place press into a one-cycle set strobe with row/col codes, and rejects moves
//  to occupied cells. Watches game_state to lock input after a win or draw. Drives the board's
//  active-high reset for new-game and power-on.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     cycles a synchronized button level must hold before it is accepted (>=1)
//  TURN_TIMEOUT     1000  cycles allowed per turn; used only when TURN_TIMER_EN is defined
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  reset_n      in   1  synchronous, active-low reset
//  btn_up/btn_down/btn_left/btn_right  in 1 each  raw async cursor buttons, active-high
//  btn_place    in   1  raw async; place symbol at cursor
//  btn_new      in   1  raw async; start a new game
//  valid        in   9  board occupancy, cell index = 8 - 3*(col-1) - (row-1)
//  game_state   in   2  00 play, 01 X(symbol 1) wins, 10 O wins, 11 draw
//  row, col     out  2  cursor codes 01/10/11 to board; never 00 after reset
//  set          out  1  one-cycle place strobe to board
//  board_reset  out  1  active-high board clear
//  turn         out  1  symbol of next move = ~^valid (1 = X)
//  illegal      out  1  one-cycle pulse: place on occupied cell
//  busy         out  1  high in ISSUE/WAIT/CHECK
//  over         out  1  high in OVER
// BEHAVIOUR
//  Reset (reset_n=0 at edge): row=col=01, set=0, illegal=0, busy=0, over=0, board_reset=1,
//   debounce counters and edge regs cleared, state=CLEAR.
//  Input path per button: 2-flop synchronizer -> counter. Stable level updates only after
//   DEBOUNCE_CYCLES equal samples. A press event is a 0->1 of the stable level, one cycle wide.
//   Press-to-event latency = 2 + DEBOUNCE_CYCLES cycles.
//  FSM:
//   CLEAR: board_reset=1 for exactly one cycle -> IDLE.
//   IDLE: accepts events in priority new > place > moves.
//    - new -> CLEAR; cursor to (01,01).
//    - place, valid[idx]=1 -> illegal=1 next cycle, stay IDLE.
//    - place, cell free -> ISSUE.
//    - moves: up/down change row, left/right change col, 01<->11 wrap (up from 01 -> 11,
//      down from 11 -> 01). Up+down together cancel; left+right cancel. Row and col moves
//      apply together. A move in the same cycle as place is discarded; place uses the pre-move cursor.
//   ISSUE: set=1 for this cycle only; row/col held -> WAIT.
//   WAIT: one cycle for board registers to update -> CHECK.
//   CHECK: game_state!=00 -> OVER, else -> IDLE.
//   OVER: over=1; only btn_new is honoured (-> CLEAR); all other events are dropped.
//  Events in ISSUE/WAIT/CHECK/CLEAR are dropped, not queued. btn_new in busy states is also
//   dropped, so the user must re-press.
//  Place-accept to set: 1 cycle. Accept to next IDLE: 3 cycles.
//  row/col change only in IDLE or CLEAR, so they are stable whenever set=1.
//  reset_n low mid-operation: immediate return to reset values at that edge. A pending set is
//   cancelled, and board_reset follows on the next cycle via CLEAR.
// CONFIGURATION
//  TURN_TIMER_EN defined:
//   - a 32-bit turn counter counts in IDLE and clears on any accepted place, on CLEAR and on reset.
//   - When count reaches TURN_TIMEOUT-1 in IDLE with no event, row/col load the first free cell
//     scanning idx 8 down to 0, the FSM enters ISSUE, and a one-cycle output timeout=1 pulses.
//   - Timer frozen outside IDLE.
//  TURN_TIMER_EN undefined: no counter and no timeout port; no auto-move.
// TESTING
//  reset_n=0 2 cycles then 1 -> row=col=01, board_reset=1 for exactly 1 cycle after release, over=0
//  btn_down held 10 cycles (DEBOUNCE_CYCLES=4) -> row 01->10 once, 6 cycles after press; 3 presses -> row=01 (wrap)
//  place at (01,01) on empty board -> set=1 one cycle with row=col=01, turn 1->0, busy high 3 cycles
//  place again on same cell -> no set, illegal=1 one cycle, turn unchanged
//  X fills idx 8,7,6 alternating with O -> game_state 01 -> over=1; further places ignored; btn_new -> board_reset pulse, over=0
//  TURN_TIMER_EN, TURN_TIMEOUT=20, valid=9'h100 idle -> after 20 IDLE cycles timeout=1, set=1 at row=10,col=01 (idx7)

Source files
------------

// File: rtl/move_ctrl.sv
// move_ctrl: debounced button front end, cursor and move sequencer for the tic-tac-toe board.
// Define TURN_TIMER_EN to add the per-turn timeout auto-move and the timeout output.
module move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       btn_new,
  input  logic [8:0] valid,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       board_reset,
  output logic       turn,
  output logic       illegal,
  output logic       busy,
  output logic       over
`ifdef TURN_TIMER_EN
  , output logic     timeout
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] CLEAR = 3'd0, IDLE = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, CHECK = 3'd4, OVER = 3'd5;
  logic [5:0] raw, s1, s2, level, ev;
  logic [5:0][CW-1:0] cnt;
  logic [2:0] state, state_nx;
  logic [1:0] row_nx, col_nx, row_mv, col_mv;
  logic [3:0] idx;
  logic bad;
`ifdef TURN_TIMER_EN
  logic [31:0] tcnt;
  logic [1:0] free_row, free_col;
  logic found, hit;
`endif
  assign raw = {btn_new, btn_place, btn_right, btn_left, btn_down, btn_up};
  assign idx = 4'd12 - 4'd3 * {2'b00, col} - {2'b00, row};
  assign set = state == ISSUE;
  assign board_reset = state == CLEAR;
  assign busy = state == ISSUE || state == WAIT || state == CHECK;
  assign over = state == OVER;
  assign turn = ~^valid;
  // An event fires on the sample that commits a new high level, so the FSM acts on that same edge
  always_comb begin
    ev = '0;
    for (int i = 0; i < 6; i++)
      ev[i] = s2[i] & ~level[i] & (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      level <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 6; i++)
        if (s2[i] == level[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  assign row_mv = (ev[0] & ~ev[1]) ? (row == 2'd1 ? 2'd3 : row - 2'd1) :
                  (ev[1] & ~ev[0]) ? (row == 2'd3 ? 2'd1 : row + 2'd1) : row;
  assign col_mv = (ev[2] & ~ev[3]) ? (col == 2'd1 ? 2'd3 : col - 2'd1) :
                  (ev[3] & ~ev[2]) ? (col == 2'd3 ? 2'd1 : col + 2'd1) : col;
`ifdef TURN_TIMER_EN
  always_comb begin
    found = 1'b0;
    free_row = 2'd1;
    free_col = 2'd1;
    for (int k = 0; k < 9; k++)
      if (!found && !valid[8-k]) begin
        found = 1'b1;
        free_row = 2'(k % 3 + 1);
        free_col = 2'(k / 3 + 1);
      end
  end
`endif
  always_comb begin
    state_nx = state;
    row_nx = row;
    col_nx = col;
    bad = 1'b0;
`ifdef TURN_TIMER_EN
    hit = 1'b0;
`endif
    if (state == CLEAR) state_nx = IDLE;
    else if (state == IDLE) begin
      if (ev[5]) begin
        state_nx = CLEAR;
        row_nx = 2'd1;
        col_nx = 2'd1;
      end else if (ev[4]) begin
        if (valid[idx]) bad = 1'b1;
        else state_nx = ISSUE;
      end else if (|ev[3:0]) begin
        row_nx = row_mv;
        col_nx = col_mv;
      end
`ifdef TURN_TIMER_EN
      else if (tcnt == 32'(TURN_TIMEOUT - 1) && found) begin
        state_nx = ISSUE;
        row_nx = free_row;
        col_nx = free_col;
        hit = 1'b1;
      end
`endif
    end else if (state == ISSUE) state_nx = WAIT;
    else if (state == WAIT) state_nx = CHECK;
    else if (state == CHECK) state_nx = |game_state ? OVER : IDLE;
    else if (state == OVER && ev[5]) begin
      state_nx = CLEAR;
      row_nx = 2'd1;
      col_nx = 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR;
      row <= 2'd1;
      col <= 2'd1;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      row <= row_nx;
      col <= col_nx;
      illegal <= bad;
    end
  end
`ifdef TURN_TIMER_EN
  always_ff @(posedge clk) begin
    if (!reset_n || state == CLEAR || state_nx == ISSUE) tcnt <= '0;
    else if (state == IDLE) tcnt <= tcnt + 32'd1;
    timeout <= reset_n & hit;
  end
`endif
endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: directed tests of debounce, cursor, place/illegal, win lock-out and new game.
module tb_move_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] btn = '0;
  logic [8:0] valid = '0;
  logic [8:0] xs = '0;
  logic [1:0] game_state;
  logic [1:0] row, col;
  logic set, board_reset, turn, illegal, busy, over;
  logic [3:0] bidx;
  int checks = 0;
  int errors = 0;
`ifdef TURN_TIMER_EN
  logic timeout;
  move_ctrl #(.DEBOUNCE_CYCLES(4), .TURN_TIMEOUT(20)) dut (
`else
  move_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
`endif
    .clk(clk), .reset_n(reset_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_place(btn[4]), .btn_new(btn[5]),
    .valid(valid), .game_state(game_state),
    .row(row), .col(col), .set(set), .board_reset(board_reset), .turn(turn),
    .illegal(illegal), .busy(busy), .over(over)
`ifdef TURN_TIMER_EN
    , .timeout(timeout)
`endif
  );
  always #5 clk = ~clk;
  // Board stand-in: latches occupancy and the X mask; only the left-column X line is scored
  assign bidx = 4'd12 - 4'd3 * {2'b00, col} - {2'b00, row};
  assign game_state = ((xs & 9'h1C0) == 9'h1C0) ? 2'b01 : 2'b00;
  always @(posedge clk)
    if (board_reset === 1'b1) begin
      valid <= '0;
      xs <= '0;
    end else if (set === 1'b1) begin
      valid[bidx] <= 1'b1;
      xs[bidx] <= ~^valid;
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (8) tick();
    btn[b] = 1'b0;
    repeat (8) tick();
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (row !== 2'd1 || col !== 2'd1) begin errors++; $display("FAIL reset_cursor row=%0d col=%0d exp=1,1", row, col); end
    checks++; if (set !== 1'b0 || busy !== 1'b0 || over !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags set=%b busy=%b over=%b illegal=%b exp=0", set, busy, over, illegal); end
    reset_n = 1'b1;
    checks++; if (board_reset !== 1'b1) begin errors++; $display("FAIL reset_board_reset got=%b exp=1", board_reset); end
    tick();
    checks++; if (board_reset !== 1'b0) begin errors++; $display("FAIL reset_board_reset_end got=%b exp=0", board_reset); end
  endtask
  task automatic test_move();
    btn[1] = 1'b1;
    repeat (5) tick();
    checks++; if (row !== 2'd1) begin errors++; $display("FAIL debounce_early row=%0d exp=1", row); end
    tick();
    checks++; if (row !== 2'd2) begin errors++; $display("FAIL debounce_latency row=%0d exp=2", row); end
    repeat (4) tick();
    checks++; if (row !== 2'd2) begin errors++; $display("FAIL debounce_once row=%0d exp=2", row); end
    btn[1] = 1'b0;
    repeat (8) tick();
    press(1);
    checks++; if (row !== 2'd3) begin errors++; $display("FAIL move_down2 row=%0d exp=3", row); end
    press(1);
    checks++; if (row !== 2'd1) begin errors++; $display("FAIL move_down_wrap row=%0d exp=1", row); end
    press(0);
    checks++; if (row !== 2'd3) begin errors++; $display("FAIL move_up_wrap row=%0d exp=3", row); end
    press(1);
    press(2);
    checks++; if (row !== 2'd1 || col !== 2'd3) begin errors++; $display("FAIL move_left_wrap row=%0d col=%0d exp=1,3", row, col); end
    press(3);
    checks++; if (col !== 2'd1) begin errors++; $display("FAIL move_right_wrap col=%0d exp=1", col); end
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
    checks++; if (row !== 2'd1 || col !== 2'd2) begin errors++; $display("FAIL move_cancel row=%0d col=%0d exp=1,2", row, col); end
    press(2);
  endtask
  task automatic test_place();
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL place_turn_before got=%b exp=1", turn); end
    btn[4] = 1'b1;
    repeat (5) tick();
    checks++; if (set !== 1'b0) begin errors++; $display("FAIL place_early set=%b exp=0", set); end
    tick();
    checks++; if (set !== 1'b1 || busy !== 1'b1 || row !== 2'd1 || col !== 2'd1) begin errors++; $display("FAIL place_set set=%b busy=%b row=%0d col=%0d exp=1,1,1,1", set, busy, row, col); end
    tick();
    checks++; if (set !== 1'b0 || busy !== 1'b1 || turn !== 1'b0) begin errors++; $display("FAIL place_wait set=%b busy=%b turn=%b exp=0,1,0", set, busy, turn); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL place_check busy=%b exp=1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || valid !== 9'h100) begin errors++; $display("FAIL place_done busy=%b valid=%h exp=0,100", busy, valid); end
    btn[4] = 1'b0;
    repeat (8) tick();
  endtask
  task automatic test_illegal();
    btn[4] = 1'b1;
    repeat (6) tick();
    checks++; if (illegal !== 1'b1 || set !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_pulse illegal=%b set=%b busy=%b exp=1,0,0", illegal, set, busy); end
    tick();
    checks++; if (illegal !== 1'b0 || turn !== 1'b0 || valid !== 9'h100) begin errors++; $display("FAIL illegal_end illegal=%b turn=%b valid=%h exp=0,0,100", illegal, turn, valid); end
    btn[4] = 1'b0;
    repeat (8) tick();
  endtask
  task automatic test_win();
    press(3); press(4);
    press(2); press(1); press(4);
    press(3); press(4);
    press(2); press(1); press(4);
    checks++; if (over !== 1'b1 || busy !== 1'b0 || valid !== 9'h1F0) begin errors++; $display("FAIL win_over over=%b busy=%b valid=%h exp=1,0,1f0", over, busy, valid); end
    btn[4] = 1'b1;
    repeat (6) tick();
    checks++; if (illegal !== 1'b0 || set !== 1'b0 || over !== 1'b1) begin errors++; $display("FAIL over_place illegal=%b set=%b over=%b exp=0,0,1", illegal, set, over); end
    btn[4] = 1'b0;
    repeat (8) tick();
    press(3);
    checks++; if (row !== 2'd3 || col !== 2'd1) begin errors++; $display("FAIL over_move row=%0d col=%0d exp=3,1", row, col); end
    btn[5] = 1'b1;
    repeat (5) tick();
    checks++; if (board_reset !== 1'b0 || over !== 1'b1) begin errors++; $display("FAIL new_early board_reset=%b over=%b exp=0,1", board_reset, over); end
    tick();
    checks++; if (board_reset !== 1'b1 || over !== 1'b0 || row !== 2'd1 || col !== 2'd1) begin errors++; $display("FAIL new_clear board_reset=%b over=%b row=%0d col=%0d exp=1,0,1,1", board_reset, over, row, col); end
    tick();
    checks++; if (board_reset !== 1'b0 || valid !== 9'h000 || turn !== 1'b1) begin errors++; $display("FAIL new_done board_reset=%b valid=%h turn=%b exp=0,000,1", board_reset, valid, turn); end
    btn[5] = 1'b0;
    repeat (8) tick();
  endtask
  task automatic test_back_to_back();
    btn[4] = 1'b1;
    tick();
    btn[1] = 1'b1;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
    checks++; if (row !== 2'd1 || valid !== 9'h100 || busy !== 1'b0) begin errors++; $display("FAIL busy_drop row=%0d valid=%h busy=%b exp=1,100,0", row, valid, busy); end
    btn[4] = 1'b1;
    btn[3] = 1'b1;
    repeat (6) tick();
    checks++; if (illegal !== 1'b1 || col !== 2'd1) begin errors++; $display("FAIL place_move_illegal illegal=%b col=%0d exp=1,1", illegal, col); end
    btn = '0;
    repeat (8) tick();
    press(1);
    btn[4] = 1'b1;
    btn[3] = 1'b1;
    repeat (6) tick();
    checks++; if (set !== 1'b1 || row !== 2'd2 || col !== 2'd1) begin errors++; $display("FAIL place_move_set set=%b row=%0d col=%0d exp=1,2,1", set, row, col); end
    btn = '0;
    repeat (8) tick();
    checks++; if (col !== 2'd1 || valid !== 9'h180) begin errors++; $display("FAIL place_move_after col=%0d valid=%h exp=1,180", col, valid); end
  endtask
  task automatic test_midreset();
    press(3);
    btn[4] = 1'b1;
    repeat (6) tick();
    checks++; if (set !== 1'b1 || row !== 2'd2 || col !== 2'd2) begin errors++; $display("FAIL midreset_set set=%b row=%0d col=%0d exp=1,2,2", set, row, col); end
    reset_n = 1'b0;
    tick();
    btn = '0;
    checks++; if (set !== 1'b0 || busy !== 1'b0 || board_reset !== 1'b1 || row !== 2'd1 || col !== 2'd1) begin errors++; $display("FAIL midreset set=%b busy=%b board_reset=%b row=%0d col=%0d exp=0,0,1,1,1", set, busy, board_reset, row, col); end
    reset_n = 1'b1;
    tick();
    checks++; if (board_reset !== 1'b0 || valid !== 9'h000) begin errors++; $display("FAIL midreset_after board_reset=%b valid=%h exp=0,000", board_reset, valid); end
    repeat (8) tick();
  endtask
`ifdef TURN_TIMER_EN
  task automatic test_timeout();
    btn[4] = 1'b1;
    repeat (6) tick();
    btn[4] = 1'b0;
    repeat (22) tick();
    checks++; if (timeout !== 1'b0 || set !== 1'b0) begin errors++; $display("FAIL timeout_early timeout=%b set=%b exp=0,0", timeout, set); end
    tick();
    checks++; if (timeout !== 1'b1 || set !== 1'b1 || row !== 2'd2 || col !== 2'd1) begin errors++; $display("FAIL timeout_fire timeout=%b set=%b row=%0d col=%0d exp=1,1,2,1", timeout, set, row, col); end
    tick();
    checks++; if (timeout !== 1'b0 || set !== 1'b0) begin errors++; $display("FAIL timeout_end timeout=%b set=%b exp=0,0", timeout, set); end
  endtask
`endif
  initial begin
    test_reset();
    test_move();
    test_place();
    test_illegal();
    test_win();
    test_back_to_back();
    test_midreset();
`ifdef TURN_TIMER_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
